// File: rtl/wb_pkg.sv
// Writeback / register file shared definitions: widths, the hardwired zero
// register and the commit-source selector.
package wb_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;
  localparam int NREGS  = 2 ** REG_AW;

  localparam logic [REG_AW-1:0] ZERO_REG = '0;

  // Which producer owns this cycle's single register-file write port.
  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_ALU,
    SRC_LSU,
    SRC_PEND
  } commit_src_e;

endpackage

// File: rtl/wb_pending_buf.sv
// One-entry holding buffer for a load result that lost the write port to
// the ALU. Load has priority over drain so a same-cycle drain+load refills.
module wb_pending_buf
  import wb_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              drain,
  input  logic [REG_AW-1:0] in_rd,
  input  logic [XLEN-1:0]   in_data,
  output logic              pend_valid,
  output logic [REG_AW-1:0] pend_rd,
  output logic [XLEN-1:0]   pend_data
);

  logic              valid_d, valid_q;
  logic [REG_AW-1:0] rd_d,    rd_q;
  logic [XLEN-1:0]   data_d,  data_q;

  // Next-state: drain empties the entry, load captures a new beat.
  always_comb begin
    valid_d = valid_q;
    rd_d    = rd_q;
    data_d  = data_q;
    if (drain) valid_d = 1'b0;
    if (load) begin
      valid_d = 1'b1;
      rd_d    = in_rd;
      data_d  = in_data;
    end
  end

  // State update with synchronous active-low reset of the valid bit.
  always_ff @(posedge clk) begin
    // NOTE: only the valid bit needs reset; the payload is never observed while valid is low.
    if (!rst) valid_q <= 1'b0;
    else      valid_q <= valid_d;
    rd_q   <= rd_d;
    data_q <= data_d;
  end

  assign pend_valid = valid_q;
  assign pend_rd    = rd_q;
  assign pend_data  = data_q;

endmodule

// File: rtl/wb_regfile.sv
// Writeback stage and integer register file. Merges the ALU result bus with
// the load stream through a one-entry pending buffer, commits one result per
// cycle and serves two bypassed read ports.
// Optional feature macro: WB_SCOREBOARD_EN adds issue-side busy tracking.
module wb_regfile
  import wb_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] alu_rd,
  input  logic              alu_out_en,
  input  logic [XLEN-1:0]   alu_rd_data,
  output logic              wb_stall,
  input  logic [REG_AW-1:0] lsu_rd,
  input  logic              lsu_valid,
  input  logic [XLEN-1:0]   lsu_rd_data,
  output logic              lsu_ready,
  input  logic [REG_AW-1:0] rs1_addr,
  input  logic [REG_AW-1:0] rs2_addr,
  output logic [XLEN-1:0]   rs1_data,
  output logic [XLEN-1:0]   rs2_data
`ifdef WB_SCOREBOARD_EN
  ,
  input  logic              issue_en,
  input  logic [REG_AW-1:0] issue_rd,
  output logic              rs1_busy,
  output logic              rs2_busy
`endif
);

  logic              pend_valid;
  logic [REG_AW-1:0] pend_rd;
  logic [XLEN-1:0]   pend_data;
  logic              pend_load, pend_drain, lsu_xfer;
  commit_src_e       commit_src;
  logic [REG_AW-1:0] commit_rd;
  logic [XLEN-1:0]   commit_data;
  logic              commit_we;

  logic [XLEN-1:0] regs_d [NREGS];
  logic [XLEN-1:0] regs_q [NREGS];

  wb_pending_buf u_pend (
    .clk       (clk),
    .rst       (rst),
    .load      (pend_load),
    .drain     (pend_drain),
    .in_rd     (lsu_rd),
    .in_data   (lsu_rd_data),
    .pend_valid(pend_valid),
    .pend_rd   (pend_rd),
    .pend_data (pend_data)
  );

  assign lsu_ready = rst && !pend_valid;
  assign lsu_xfer  = lsu_valid && lsu_ready;
  assign wb_stall  = rst && pend_valid && alu_out_en;

  // Commit arbitration: pending entry first, then ALU (parking a colliding load beat), then LSU.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    commit_src = SRC_NONE;
    pend_load  = 1'b0;
    pend_drain = 1'b0;
    if (pend_valid) begin
      commit_src = SRC_PEND;
      pend_drain = 1'b1;
    end else if (lsu_xfer && alu_out_en) begin
      commit_src = SRC_ALU;
      pend_load  = 1'b1;
    end else if (lsu_xfer) begin
      commit_src = SRC_LSU;
    end else if (alu_out_en) begin
      commit_src = SRC_ALU;
    end
  end

  // Route the selected producer onto the single write port.
  always_comb begin
    commit_rd   = ZERO_REG;
    commit_data = '0;
    unique case (commit_src)
      SRC_ALU:  begin commit_rd = alu_rd;  commit_data = alu_rd_data; end
      SRC_LSU:  begin commit_rd = lsu_rd;  commit_data = lsu_rd_data; end
      SRC_PEND: begin commit_rd = pend_rd; commit_data = pend_data;   end
      default:  ;
    endcase
  end

  // x0 writes still consume the slot but never reach the array or bypass.
  assign commit_we = rst && (commit_src != SRC_NONE) && (commit_rd != ZERO_REG);

  // Register array next-state: at most one entry changes per cycle.
  always_comb begin
    regs_d = regs_q;
    if (commit_we) regs_d[commit_rd] = commit_data;
  end

  // Register array update; the whole file clears on reset.
  always_ff @(posedge clk) begin
    // NOTE: this array is architecturally visible after reset, so unlike a plain RAM it must be cleared.
    if (!rst) regs_q <= '{default: '0};
    else      regs_q <= regs_d;
  end

  // Read ports: x0 is constant zero, a same-cycle commit is forwarded.
  always_comb begin
    rs1_data = regs_q[rs1_addr];
    rs2_data = regs_q[rs2_addr];
    if (commit_we && (rs1_addr == commit_rd)) rs1_data = commit_data;
    if (commit_we && (rs2_addr == commit_rd)) rs2_data = commit_data;
    if (rs1_addr == ZERO_REG) rs1_data = '0;
    if (rs2_addr == ZERO_REG) rs2_data = '0;
  end

`ifdef WB_SCOREBOARD_EN
  logic [NREGS-1:0] busy_d, busy_q;

  // Busy tracking: commit clears, issue sets afterwards so set wins a tie.
  always_comb begin
    busy_d = busy_q;
    if (commit_we) busy_d[commit_rd] = 1'b0;
    if (issue_en)  busy_d[issue_rd]  = 1'b1;
    busy_d[ZERO_REG] = 1'b0;
  end

  // Busy bits clear on reset.
  always_ff @(posedge clk) begin
    if (!rst) busy_q <= '0;
    else      busy_q <= busy_d;
  end

  assign rs1_busy = busy_q[rs1_addr] && !(commit_we && (commit_rd == rs1_addr));
  assign rs2_busy = busy_q[rs2_addr] && !(commit_we && (commit_rd == rs2_addr));
`endif

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: directed scenarios followed by
// randomized traffic against a queue-based reference model.
// Build with WB_SCOREBOARD_EN defined to also exercise the busy outputs.
module tb_wb_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  alu_rd, lsu_rd, rs1_addr, rs2_addr;
  logic        alu_out_en, lsu_valid;
  logic [31:0] alu_rd_data, lsu_rd_data;
  logic        wb_stall, lsu_ready;
  logic [31:0] rs1_data, rs2_data;
`ifdef WB_SCOREBOARD_EN
  logic        issue_en;
  logic [4:0]  issue_rd;
  logic        rs1_busy, rs2_busy;
`endif

  always #5 clk = ~clk;

  wb_regfile dut (
    .clk        (clk),
    .rst        (rst),
    .alu_rd     (alu_rd),
    .alu_out_en (alu_out_en),
    .alu_rd_data(alu_rd_data),
    .wb_stall   (wb_stall),
    .lsu_rd     (lsu_rd),
    .lsu_valid  (lsu_valid),
    .lsu_rd_data(lsu_rd_data),
    .lsu_ready  (lsu_ready),
    .rs1_addr   (rs1_addr),
    .rs2_addr   (rs2_addr),
    .rs1_data   (rs1_data),
    .rs2_data   (rs2_data)
`ifdef WB_SCOREBOARD_EN
    ,
    .issue_en   (issue_en),
    .issue_rd   (issue_rd),
    .rs1_busy   (rs1_busy),
    .rs2_busy   (rs2_busy)
`endif
  );

  // Reference model: architectural registers, FIFO of parked load results, busy set.
  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wr_t;

  logic [31:0] m_regs [32];
  wr_t         m_pend [$];
  logic        m_busy [32];
  logic        m_init = 1'b0;

  // Per-cycle results computed at the negedge, applied at the posedge.
  logic [31:0] n_regs [32];
  logic        n_pop, n_push;
  wr_t         n_push_val;
  logic        c_we;
  logic [4:0]  c_rd;
  logic        last_stall, last_lsu_wait;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // First half-cycle: predict and check outputs for the inputs now applied.
  task automatic step_a();
    logic exp_ready, exp_stall;
    logic [31:0] c_data;
    @(negedge clk);
    exp_ready = rst && (m_pend.size() == 0);
    exp_stall = rst && (m_pend.size() != 0) && alu_out_en;
    check("lsu_ready", {31'b0, lsu_ready}, {31'b0, exp_ready});
    check("wb_stall",  {31'b0, wb_stall},  {31'b0, exp_stall});

    c_we = 1'b0; c_rd = '0; c_data = '0; n_pop = 1'b0; n_push = 1'b0; n_push_val = '0;
    if (rst) begin
      if (m_pend.size() != 0) begin
        c_we = 1'b1; c_rd = m_pend[0].rd; c_data = m_pend[0].data; n_pop = 1'b1;
      end else if (lsu_valid) begin
        if (alu_out_en) begin
          c_we = 1'b1; c_rd = alu_rd; c_data = alu_rd_data;
          n_push = 1'b1; n_push_val = '{rd: lsu_rd, data: lsu_rd_data};
        end else begin
          c_we = 1'b1; c_rd = lsu_rd; c_data = lsu_rd_data;
        end
      end else if (alu_out_en) begin
        c_we = 1'b1; c_rd = alu_rd; c_data = alu_rd_data;
      end
    end
    n_regs = m_regs;
    if (c_we && c_rd != 5'd0) n_regs[c_rd] = c_data;

    // A read sees the register's value as it stands after this cycle's commit.
    if (m_init) begin
      check("rs1_data", rs1_data, (rs1_addr == 5'd0) ? 32'd0 : n_regs[rs1_addr]);
      check("rs2_data", rs2_data, (rs2_addr == 5'd0) ? 32'd0 : n_regs[rs2_addr]);
`ifdef WB_SCOREBOARD_EN
      check("rs1_busy", {31'b0, rs1_busy},
            {31'b0, m_busy[rs1_addr] && !(c_we && c_rd == rs1_addr && rs1_addr != 5'd0)});
      check("rs2_busy", {31'b0, rs2_busy},
            {31'b0, m_busy[rs2_addr] && !(c_we && c_rd == rs2_addr && rs2_addr != 5'd0)});
`endif
    end
    last_stall    = exp_stall;
    last_lsu_wait = lsu_valid && !exp_ready;
  endtask

  // Second half-cycle: clock edge, then advance the model.
  task automatic step_b();
    @(posedge clk);
    if (!rst) begin
      foreach (m_regs[i]) m_regs[i] = '0;
      foreach (m_busy[i]) m_busy[i] = 1'b0;
      m_pend.delete();
      m_init = 1'b1;
    end else begin
      m_regs = n_regs;
      if (n_pop) void'(m_pend.pop_front());
      if (n_push) m_pend.push_back(n_push_val);
`ifdef WB_SCOREBOARD_EN
      if (c_we) m_busy[c_rd] = 1'b0;
      if (issue_en && issue_rd != 5'd0) m_busy[issue_rd] = 1'b1;
`endif
    end
    #1;
  endtask

  task automatic step();
    step_a();
    step_b();
  endtask

  task automatic idle_inputs();
    alu_out_en = 1'b0; alu_rd = '0; alu_rd_data = '0;
    lsu_valid = 1'b0; lsu_rd = '0; lsu_rd_data = '0;
    rs1_addr = '0; rs2_addr = '0;
`ifdef WB_SCOREBOARD_EN
    issue_en = 1'b0; issue_rd = '0;
`endif
  endtask

  function automatic logic [4:0] rnd_rd();
    if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
    return 5'($urandom_range(0, 7));
  endfunction

  initial begin
    rst = 1'b0;
    idle_inputs();
    #1;

    // Reset with an ALU write pending on the bus: nothing may commit.
    alu_out_en = 1'b1; alu_rd = 5'd5; alu_rd_data = 32'hDEAD_BEEF;
    rs1_addr = 5'd5;
    step();
    step();
    rst = 1'b1;
    idle_inputs();
    rs1_addr = 5'd5; rs2_addr = 5'd3;
    step_a();
    check("reset_x5", rs1_data, 32'd0);
    check("reset_x3", rs2_data, 32'd0);
    step_b();

    // ALU write visible through bypass, then from the array.
    alu_out_en = 1'b1; alu_rd = 5'd3; alu_rd_data = 32'h1234_5678; rs1_addr = 5'd3;
    step_a();
    check("alu_bypass", rs1_data, 32'h1234_5678);
    step_b();
    alu_out_en = 1'b0;
    step_a();
    check("alu_array", rs1_data, 32'h1234_5678);
    step_b();

    // ALU/LSU collision: ALU first, parked load next, ready low for one cycle.
    alu_out_en = 1'b1; alu_rd = 5'd4; alu_rd_data = 32'hA;
    lsu_valid = 1'b1; lsu_rd = 5'd6; lsu_rd_data = 32'hB;
    rs1_addr = 5'd4; rs2_addr = 5'd6;
    step_a();
    check("coll_ready0", {31'b0, lsu_ready}, 32'd1);
    check("coll_x4", rs1_data, 32'hA);
    step_b();
    idle_inputs(); rs1_addr = 5'd4; rs2_addr = 5'd6;
    step_a();
    check("coll_ready1", {31'b0, lsu_ready}, 32'd0);
    check("coll_x6", rs2_data, 32'hB);
    step_b();
    step_a();
    check("coll_ready2", {31'b0, lsu_ready}, 32'd1);
    step_b();

    // Stall: park a load, then offer a held ALU result.
    alu_out_en = 1'b1; alu_rd = 5'd8; alu_rd_data = 32'h88;
    lsu_valid = 1'b1; lsu_rd = 5'd9; lsu_rd_data = 32'h99;
    step();
    lsu_valid = 1'b0;
    alu_rd = 5'd10; alu_rd_data = 32'h77; rs1_addr = 5'd10; rs2_addr = 5'd9;
    step_a();
    check("stall_on", {31'b0, wb_stall}, 32'd1);
    check("stall_x10_old", rs1_data, 32'd0);
    check("stall_x9", rs2_data, 32'h99);
    step_b();
    step_a();
    check("stall_off", {31'b0, wb_stall}, 32'd0);
    check("stall_x10", rs1_data, 32'h77);
    step_b();

    // Same rd from both sources: the load value is final.
    alu_rd = 5'd12; alu_rd_data = 32'h1111;
    lsu_valid = 1'b1; lsu_rd = 5'd12; lsu_rd_data = 32'h2222; rs1_addr = 5'd12;
    step();
    idle_inputs(); rs1_addr = 5'd12;
    step();
    step_a();
    check("same_rd_final", rs1_data, 32'h2222);
    step_b();

    // x0 write: discarded, no stall, no forwarding.
    alu_out_en = 1'b1; alu_rd = 5'd0; alu_rd_data = 32'hFFFF_FFFF; rs1_addr = 5'd0;
    step_a();
    check("x0_read", rs1_data, 32'd0);
    check("x0_stall", {31'b0, wb_stall}, 32'd0);
    step_b();
    idle_inputs();

`ifdef WB_SCOREBOARD_EN
    // Scoreboard: issue x7, observe busy, clear in the commit cycle.
    issue_en = 1'b1; issue_rd = 5'd7;
    step();
    issue_en = 1'b0; rs1_addr = 5'd7;
    step_a();
    check("sb_busy", {31'b0, rs1_busy}, 32'd1);
    step_b();
    alu_out_en = 1'b1; alu_rd = 5'd7; alu_rd_data = 32'h7777;
    step_a();
    check("sb_clear_commit", {31'b0, rs1_busy}, 32'd0);
    step_b();
    alu_out_en = 1'b0;
    step_a();
    check("sb_clear_after", {31'b0, rs1_busy}, 32'd0);
    step_b();
`endif

    // Randomized traffic; producers hold their outputs until accepted.
    last_stall = 1'b0; last_lsu_wait = 1'b0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      rst = !(cyc == 300 || cyc == 301);
      if (!(last_stall && alu_out_en)) begin
        alu_out_en  = ($urandom_range(0, 2) != 0);
        alu_rd      = rnd_rd();
        alu_rd_data = $urandom;
      end
      if (!last_lsu_wait) begin
        lsu_valid   = ($urandom_range(0, 1) != 0);
        lsu_rd      = rnd_rd();
        lsu_rd_data = $urandom;
      end
      rs1_addr = rnd_rd();
      rs2_addr = rnd_rd();
`ifdef WB_SCOREBOARD_EN
      issue_en = ($urandom_range(0, 3) == 0);
      issue_rd = rnd_rd();
`endif
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
